uart_tx_arbiter: RTL

Shares one uart_tx instance between NUM_REQ independent byte producers, for example the data processor, a status reporter and a debug dump. Arbitration is round-robin with a per-requester valid/ready handshake. The granted byte goes to the transmitter as a one-cycle tx_data_valid pulse. uart_tx has no busy output, so the block times each serial frame internally from the UART parameters and holds off further grants until the frame has finished on the line.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and frame-timing helpers
// used by the TX/RX blocks and the TX arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  function automatic int unsigned clks_per_bit(int unsigned clock_freq,
                                               int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Parity is passed as its packed string ("NONE", "ODD", "EVEN").
  function automatic int unsigned frame_bits(int unsigned data_bits,
                                             logic [31:0] parity,
                                             int unsigned stop_bits);
    return 1 + data_bits + ((parity != "NONE") ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer handshake plus the transmitter-side strobe/data pair.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_data_valid;
  logic [DATA_BITS-1:0]         tx_data;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  tx_data_valid,
    input  tx_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output tx_data_valid,
    output tx_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned pos;
      pos = (32'(ptr) + (N - 1 - k)) % N;
      if (req[IDX_W'(pos)]) begin
        gnt_idx = IDX_W'(pos);
        any     = 1'b1;
      end
    end
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers; frames
// are timed internally since the transmitter has no busy output.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned DATA_BITS    = 8,
  parameter logic [31:0] PARITY       = "NONE",
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  uart_tx_arbiter_if.slave           bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned FRAME_BITS   = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int unsigned HOLDOFF      = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES;
  localparam int unsigned CNT_W        = $clog2(HOLDOFF + 1);
  localparam int unsigned ID_W         = $clog2(NUM_REQ);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_arbiter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ID_W-1:0]      ptr;
  logic                 tx_data_valid_q;
  logic [DATA_BITS-1:0] tx_data_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [DATA_BITS-1:0] sel_data;
  logic                 grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign grant = (state == IDLE) && en && arb_any;

  always_comb begin
    bus.req_ready = grant ? arb_gnt : '0;
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // frame_done and busy are registered one step early so they line up with
  // the final WAIT cycle and the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      ptr             <= '0;
      tx_data_valid_q <= 1'b0;
      tx_data_q       <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      tx_data_valid_q <= 1'b0;
      frame_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data_q       <= sel_data;
            grant_id        <= arb_idx;
            ptr             <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
            tx_data_valid_q <= 1'b1;
            busy            <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          cnt   <= CNT_W'(HOLDOFF - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt        <= cnt - CNT_W'(1);
            frame_done <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.tx_data       = tx_data_q;

endmodule
